seq_mul_n: RTL

- Parametrised sequential shift-add multiplier for the execution unit.
- Supports signed and unsigned operands per operation.
- Uses a valid/ready handshake on both input and output, and holds the result until it is consumed.
- Produces a 2N-bit product split into upper and lower halves, plus a flag that says whether the product fits in N bits.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/add_n.sv | 13 +
 rtl/seq_mul_n.sv | 116 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_DEFAULT = 32;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // One guard bit above the 2N-bit partial product.
  function automatic int acc_w(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/add_n.sv
// Parametrised N-bit adder with carry out, used for the per-iteration accumulate.
module add_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mul_n.sv
// Sequential shift-add multiplier, signed or unsigned per operation, with
// valid/ready handshakes and a held 2N-bit result.
module seq_mul_n
  import mul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_signed,
  input  logic [N-1:0] multiplier,
  input  logic [N-1:0] multiplicand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] product_upper,
  output logic [N-1:0] product_lower,
  output logic         fits_lower,
  output logic         busy
);

  localparam int CW = cnt_w(N);
  localparam int AW = acc_w(N);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [N-1:0]    mag_b;
  logic            neg;
  logic            signed_q;

  logic [N-1:0]    mag_a_in, mag_b_in;
  logic [N-1:0]    sum;
  logic            cout;
  logic [2*N-1:0]  res;
  logic            fits_nx;
  logic            last;

  // Most-negative operand negates to 2^(N-1), which still fits as an unsigned magnitude.
  assign mag_a_in = (is_signed && multiplier[N-1])   ? -multiplier   : multiplier;
  assign mag_b_in = (is_signed && multiplicand[N-1]) ? -multiplicand : multiplicand;
  assign last     = (cnt == CW'(N - 1));

  add_n #(.N(N)) u_add (
    .a    (acc[2*N-1:N]),
    .b    (mag_b),
    .sum  (sum),
    .cout (cout)
  );

  assign res     = neg ? -acc[2*N-1:0] : acc[2*N-1:0];
  assign fits_nx = signed_q ? (res[2*N-1:N] == {N{res[N-1]}})
                            : (res[2*N-1:N] == '0);

  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC) || (state == FIX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (last) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      acc           <= '0;
      mag_b         <= '0;
      neg           <= 1'b0;
      signed_q      <= 1'b0;
      out_valid     <= 1'b0;
      product_upper <= '0;
      product_lower <= '0;
      fits_lower    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signed_q <= is_signed;
            neg      <= is_signed & (multiplier[N-1] ^ multiplicand[N-1]);
            mag_b    <= mag_b_in;
            acc      <= {{(N+1){1'b0}}, mag_a_in};
            cnt      <= '0;
          end
        end
        CALC: begin
          if (acc[0]) acc <= {1'b0, cout, sum, acc[N-1:1]};
          else        acc <= acc >> 1;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          product_upper <= res[2*N-1:N];
          product_lower <= res[N-1:0];
          fits_lower    <= fits_nx;
          out_valid     <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
